// File: rtl/ber_align_counter_pkg.sv
// ber_pkg: shared constants for the BER alignment counter.
//   - FSM state encoding (enum plus legacy-style localparam constants)
//   - PRBS_PERIOD: length of one PRBS9 period, which is also the delay search range
//   - default values for the ber_align_counter parameters
package ber_pkg;

  localparam int PRBS_PERIOD = 511;

  localparam int NB_BER_DEF    = 64;
  localparam int NB_DELAY_DEF  = 9;
  localparam int WIN_LEN_DEF   = 511;
  localparam int RESYNC_TH_DEF = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SEARCH = 2'd2,
    S_LOCKED = 2'd3
  } ber_state_e;

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_FILL   = S_FILL;
  localparam logic [1:0] ST_SEARCH = S_SEARCH;
  localparam logic [1:0] ST_LOCKED = S_LOCKED;

endpackage

// File: rtl/ber_align_counter_if.sv
// ber_align_counter_if: receive-side strobe bundle feeding the BER counter.
//   i_enable  : RX enable, low freezes the block
//   i_valid   : one-cycle baud strobe
//   i_ref_bit : local transmitted PRBS9 bit (qualified by i_valid)
//   i_rx_bit  : received decided bit (qualified by i_valid)
// master drives the bundle, slave (the counter) consumes it.
interface ber_align_counter_if;
  logic i_enable;
  logic i_valid;
  logic i_ref_bit;
  logic i_rx_bit;

  modport master (output i_enable, i_valid, i_ref_bit, i_rx_bit);
  modport slave  (input  i_enable, i_valid, i_ref_bit, i_rx_bit);
endinterface

// File: rtl/ber_align_counter_ref_delay_line.sv
// ref_delay_line: history of reference bits with one indexed read port.
//   clock, reset : clock and asynchronous active-high reset
//   i_shift      : push i_bit into the history (one strobe)
//   i_bit        : reference bit of the current strobe
//   i_rd_idx     : tap index d
//   o_bit        : hist[d]; hist[0] is the current i_bit, hist[k] the bit k strobes ago
module ref_delay_line #(
  parameter int NB_DELAY = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_shift,
  input  logic                i_bit,
  input  logic [NB_DELAY-1:0] i_rd_idx,
  output logic                o_bit
);

  localparam int HIST_W = (1 << NB_DELAY) - 1;

  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] hist_d;
  logic [HIST_W:0]   hist_s;

  // Tap 0 is the live input so a zero-delay candidate compares same-strobe bits.
  assign hist_s = {hist_q, i_bit};
  assign o_bit  = hist_s[i_rd_idx];

  // Next history: shift in the current bit on a strobe, otherwise hold.
  always_comb begin
    hist_d = hist_q;
    if (i_shift) begin
      hist_d = {hist_q[HIST_W-2:0], i_bit};
    end else begin
      hist_d = hist_q;
    end
  end

  // History register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= {HIST_W{1'b0}};
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/ber_align_counter.sv
// ber_align_counter: finds the alignment delay between a local PRBS9 reference
// and the received bit stream, then counts compared bits and bit errors.
//   clock, reset   : clock and asynchronous active-high reset
//   rx_if          : strobe bundle (i_enable, i_valid, i_ref_bit, i_rx_bit)
//   o_bit_count    : compared bits since lock (saturating)
//   o_error_count  : mismatches since lock (saturating)
//   o_locked       : high while locked
//   o_delay        : selected alignment delay
// Optional feature: define BER_RESYNC_EN to re-enter the search when a locked
// window accumulates RESYNC_TH errors. Without it LOCKED is left only by reset.
module ber_align_counter
  import ber_pkg::*;
#(
  parameter int NB_BER    = NB_BER_DEF,
  parameter int NB_DELAY  = NB_DELAY_DEF,
  parameter int WIN_LEN   = WIN_LEN_DEF,
  parameter int RESYNC_TH = RESYNC_TH_DEF
) (
  input  logic                clock,
  input  logic                reset,
  ber_align_counter_if.slave  rx_if,
  output logic [NB_BER-1:0]   o_bit_count,
  output logic [NB_BER-1:0]   o_error_count,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay
);

  // Window counters are sized so that all-ones exceeds any reachable count;
  // all-ones therefore serves as the "no candidate yet" minimum.
  localparam int NB_WIN = $clog2(((WIN_LEN > RESYNC_TH) ? WIN_LEN : RESYNC_TH) + 2);
  localparam logic [NB_DELAY-1:0] LAST_D   = NB_DELAY'(PRBS_PERIOD - 1);
  localparam logic [NB_WIN-1:0]   WIN_LAST = NB_WIN'(WIN_LEN - 1);
  localparam logic [NB_WIN-1:0]   ERR_NONE = {NB_WIN{1'b1}};
  localparam logic [NB_BER-1:0]   CNT_MAX  = {NB_BER{1'b1}};
`ifdef BER_RESYNC_EN
  localparam logic [NB_WIN-1:0]   RESYNC_LIM = NB_WIN'(RESYNC_TH);
`endif

  logic [1:0]          state_q, state_d;
  logic [NB_DELAY-1:0] cand_q, cand_d;
  logic [NB_DELAY-1:0] best_q, best_d;
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
  logic [NB_WIN-1:0]   win_err_q, win_err_d;
  logic [NB_WIN-1:0]   min_q, min_d;
  logic [NB_BER-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_BER-1:0]   err_cnt_q, err_cnt_d;
  logic                locked_q, locked_d;

  logic                strobe_s;
  logic                shift_s;
  logic [NB_DELAY-1:0] rd_idx_s;
  logic                ref_tap_s;
  logic                mismatch_s;
  logic [NB_WIN-1:0]   win_err_sum_s;
  logic                win_end_s;
  logic                take_s;
  logic [NB_DELAY-1:0] best_now_s;
  logic [NB_WIN-1:0]   min_now_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [NB_BER-1:0] sat_inc(input logic [NB_BER-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + NB_BER'(1);
    end else begin
      return v;
    end
  endfunction

  assign strobe_s      = rx_if.i_valid & rx_if.i_enable;
  assign shift_s       = strobe_s & (state_q != ST_IDLE);
  assign rd_idx_s      = (state_q == ST_LOCKED) ? delay_q : cand_q;
  assign mismatch_s    = rx_if.i_rx_bit ^ ref_tap_s;
  assign win_err_sum_s = win_err_q + NB_WIN'(mismatch_s);
  assign win_end_s     = (win_cnt_q == WIN_LAST);
  // Strictly-less keeps the earlier (smaller) delay on ties.
  assign take_s        = (win_err_sum_s < min_q);
  assign best_now_s    = take_s ? cand_q : best_q;
  assign min_now_s     = take_s ? win_err_sum_s : min_q;

  ref_delay_line #(
    .NB_DELAY (NB_DELAY)
  ) u_ref_delay_line (
    .clock    (clock),
    .reset    (reset),
    .i_shift  (shift_s),
    .i_bit    (rx_if.i_ref_bit),
    .i_rd_idx (rd_idx_s),
    .o_bit    (ref_tap_s)
  );

  // Next-state logic for the FSM, search bookkeeping and the BER counters.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    best_d    = best_q;
    delay_d   = delay_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    min_d     = min_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    locked_d  = locked_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_if.i_enable) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        // cand_q doubles as the fill strobe counter; it is back at 0 for the search.
        if (strobe_s) begin
          if (cand_q == LAST_D) begin
            state_d = ST_SEARCH;
            cand_d  = {NB_DELAY{1'b0}};
          end else begin
            cand_d = cand_q + NB_DELAY'(1);
          end
        end else begin
          cand_d = cand_q;
        end
      end
      ST_SEARCH: begin
        if (strobe_s) begin
          if (win_end_s) begin
            win_cnt_d = {NB_WIN{1'b0}};
            win_err_d = {NB_WIN{1'b0}};
            min_d     = min_now_s;
            best_d    = best_now_s;
            if (cand_q == LAST_D) begin
              state_d   = ST_LOCKED;
              delay_d   = best_now_s;
              locked_d  = 1'b1;
              cand_d    = {NB_DELAY{1'b0}};
              bit_cnt_d = {NB_BER{1'b0}};
              err_cnt_d = {NB_BER{1'b0}};
            end else begin
              cand_d = cand_q + NB_DELAY'(1);
            end
          end else begin
            win_cnt_d = win_cnt_q + NB_WIN'(1);
            win_err_d = win_err_sum_s;
          end
        end else begin
          win_cnt_d = win_cnt_q;
        end
      end
      ST_LOCKED: begin
        if (strobe_s) begin
          bit_cnt_d = sat_inc(bit_cnt_q, 1'b1);
          err_cnt_d = sat_inc(err_cnt_q, mismatch_s);
`ifdef BER_RESYNC_EN
          // Too many errors in one window: restart the search, counters keep their values.
          if (win_err_sum_s >= RESYNC_LIM) begin
            state_d   = ST_SEARCH;
            locked_d  = 1'b0;
            cand_d    = {NB_DELAY{1'b0}};
            win_cnt_d = {NB_WIN{1'b0}};
            win_err_d = {NB_WIN{1'b0}};
            min_d     = ERR_NONE;
            best_d    = {NB_DELAY{1'b0}};
          end else if (win_end_s) begin
            win_cnt_d = {NB_WIN{1'b0}};
            win_err_d = {NB_WIN{1'b0}};
          end else begin
            win_cnt_d = win_cnt_q + NB_WIN'(1);
            win_err_d = win_err_sum_s;
          end
`endif
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cand_q    <= {NB_DELAY{1'b0}};
      best_q    <= {NB_DELAY{1'b0}};
      delay_q   <= {NB_DELAY{1'b0}};
      win_cnt_q <= {NB_WIN{1'b0}};
      win_err_q <= {NB_WIN{1'b0}};
      min_q     <= ERR_NONE;
      bit_cnt_q <= {NB_BER{1'b0}};
      err_cnt_q <= {NB_BER{1'b0}};
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      best_q    <= best_d;
      delay_q   <= delay_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      min_q     <= min_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
    end
  end

  assign o_bit_count   = bit_cnt_q;
  assign o_error_count = err_cnt_q;
  assign o_locked      = locked_q;
  assign o_delay       = delay_q;

endmodule

// File: tb/tb_ber_align_counter.sv
// Bench for ber_align_counter (default build, resync disabled). Two instances
// share one stimulus bundle: a 64-bit counter and an 8-bit counter for saturation.
module tb_ber_align_counter;
  import ber_pkg::*;

  localparam int W       = 12;
  localparam int LOCK_AT = PRBS_PERIOD + PRBS_PERIOD * W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ber_align_counter_if bus ();

  logic [63:0] bits64, errs64;
  logic [7:0]  bits8, errs8;
  logic        lk64, lk8;
  logic [8:0]  dly64, dly8;

  ber_align_counter #(.NB_BER(64), .NB_DELAY(9), .WIN_LEN(W), .RESYNC_TH(4)) dut64 (
    .clock(clock), .reset(reset), .rx_if(bus),
    .o_bit_count(bits64), .o_error_count(errs64), .o_locked(lk64), .o_delay(dly64));

  ber_align_counter #(.NB_BER(8), .NB_DELAY(9), .WIN_LEN(W), .RESYNC_TH(4)) dut8 (
    .clock(clock), .reset(reset), .rx_if(bus),
    .o_bit_count(bits8), .o_error_count(errs8), .o_locked(lk8), .o_delay(dly8));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Strobes are numbered from 0 after wake-up; m_refs[k] is the reference bit of strobe k.
  // Strobes 0..510 fill, the next 511*W strobes score candidate d = j / W, then lock.
  bit          m_active;
  int          m_k;
  bit          m_refs[$];
  int          m_werr[PRBS_PERIOD];
  int          m_delay;
  bit          m_locked;
  logic [63:0] m_bits, m_errs;
  int          m_bits8, m_errs8;

  function automatic void model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_refs.delete();
    foreach (m_werr[i]) m_werr[i] = 0;
    m_delay  = 0;
    m_locked = 1'b0;
    m_bits   = 64'd0;
    m_errs   = 64'd0;
    m_bits8  = 0;
    m_errs8  = 0;
  endfunction

  function automatic void model_step(input bit en, input bit val, input bit rb, input bit xb);
    int j, d, best;
    bit e;
    if (!m_active) begin
      if (en) m_active = 1'b1;
      return;
    end
    if (!(en && val)) return;
    m_refs.push_back(rb);
    if (m_k >= PRBS_PERIOD && m_k < LOCK_AT) begin
      j = m_k - PRBS_PERIOD;
      d = j / W;
      if (xb != m_refs[m_k - d]) m_werr[d]++;
      if (j == PRBS_PERIOD * W - 1) begin
        best = 0;
        for (int c = 1; c < PRBS_PERIOD; c++) if (m_werr[c] < m_werr[best]) best = c;
        m_delay  = best;
        m_locked = 1'b1;
        m_bits   = 64'd0;
        m_errs   = 64'd0;
        m_bits8  = 0;
        m_errs8  = 0;
      end
    end else if (m_k >= LOCK_AT) begin
      e = xb ^ m_refs[m_k - m_delay];
      if (m_bits != 64'hFFFF_FFFF_FFFF_FFFF) m_bits = m_bits + 64'd1;
      if (e && m_errs != 64'hFFFF_FFFF_FFFF_FFFF) m_errs = m_errs + 64'd1;
      if (m_bits8 < 255) m_bits8++;
      if (e && m_errs8 < 255) m_errs8++;
    end
    m_k++;
  endfunction

  // ---------------- per-cycle comparison ----------------
  bit chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_locked64", 64'(lk64), 64'(m_locked));
      chk("cyc_delay64", 64'(dly64), 64'(m_delay));
      chk("cyc_bits64", bits64, m_bits);
      chk("cyc_errs64", errs64, m_errs);
      chk("cyc_locked8", 64'(lk8), 64'(m_locked));
      chk("cyc_delay8", 64'(dly8), 64'(m_delay));
      chk("cyc_bits8", 64'(bits8), 64'(m_bits8));
      chk("cyc_errs8", 64'(errs8), 64'(m_errs8));
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] prbs = 9'h1FF;
  logic       txq[$];

  task automatic next_ref(output logic b);
    b    = prbs[8] ^ prbs[4];
    prbs = {prbs[7:0], b};
  endtask

  // One clock: drive at the falling edge, model follows the rising edge.
  task automatic cycle(input logic en, input logic val, input logic rb, input logic xb);
    bus.i_enable  = en;
    bus.i_valid   = val;
    bus.i_ref_bit = rb;
    bus.i_rx_bit  = xb;
    @(posedge clock);
    if (!reset) model_step(en, val, rb, xb);
    @(negedge clock);
  endtask

  // n strobes with rx = ref delayed dly strobes, optional inversions; idle gap every 16.
  task automatic send(input int n, input int dly, input int inv_period, input bit inv_all);
    logic rb, xb;
    for (int i = 0; i < n; i++) begin
      if (i % 16 == 15) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      next_ref(rb);
      txq.push_back(rb);
      if (txq.size() > dly) xb = txq[txq.size() - 1 - dly];
      else xb = 1'b0;
      if (txq.size() > 600) void'(txq.pop_front());
      if (inv_all || (inv_period > 0 && (i + 1) % inv_period == 0)) xb = ~xb;
      cycle(1'b1, 1'b1, rb, xb);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_valid  = 1'b0;
    model_reset();
    txq.delete();
    #1;
    chk({tag, "_locked"}, 64'(lk64), 64'd0);
    chk({tag, "_delay"}, 64'(dly64), 64'd0);
    chk({tag, "_bits"}, bits64, 64'd0);
    chk({tag, "_errs"}, errs64, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.i_enable  = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_ref_bit = 1'b0;
    bus.i_rx_bit  = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_locked", 64'(lk64), 64'd0);
    chk("rst_delay", 64'(dly64), 64'd0);
    chk("rst_bits", bits64, 64'd0);
    chk("rst_errs", errs64, 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Zero-error lock at delay 37: locked exactly after 511 + 511*W strobes.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send(LOCK_AT - 1, 37, 0, 1'b0);
    chk("a_prelock", 64'(lk64), 64'd0);
    send(1, 37, 0, 1'b0);
    chk("a_locked", 64'(lk64), 64'd1);
    chk("a_delay", 64'(dly64), 64'd37);
    chk("a_model_delay", 64'(m_delay), 64'd37);
    chk("a_bits0", bits64, 64'd0);
    send(500, 37, 0, 1'b0);
    chk("a_bits", bits64, 64'd500);
    chk("a_errs", errs64, 64'd0);
    chk("a_bits8_sat", 64'(bits8), 64'd255);

    // Freeze: enable low with valid toggling.
    for (int i = 0; i < 1000; i++)
      cycle(1'b0, 1'(i % 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("frz_bits", bits64, 64'd500);
    chk("frz_errs", errs64, 64'd0);
    chk("frz_delay", 64'(dly64), 64'd37);
    chk("frz_locked", 64'(lk64), 64'd1);

    // Error injection at delay 5: every 100th locked bit inverted.
    async_reset("rst_locked");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send(LOCK_AT, 5, 0, 1'b0);
    chk("b_delay", 64'(dly64), 64'd5);
    send(10000, 5, 100, 1'b0);
    chk("b_bits", bits64, 64'd10000);
    chk("b_errs", errs64, 64'd100);
    chk("b_bits8_sat", 64'(bits8), 64'd255);
    chk("b_errs8", 64'(errs8), 64'd100);

    // Reset while searching candidate 200, then a full relock and saturation.
    async_reset("rst_b");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send(PRBS_PERIOD + 200 * W + 5, 37, 0, 1'b0);
    chk("d_search_unlocked", 64'(lk64), 64'd0);
    async_reset("rst_search");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send(LOCK_AT, 37, 0, 1'b0);
    chk("d_relock", 64'(lk64), 64'd1);
    chk("d_delay", 64'(dly64), 64'd37);
    send(300, 37, 0, 1'b1);
    chk("d_bits8_sat", 64'(bits8), 64'd255);
    chk("d_errs8_sat", 64'(errs8), 64'd255);
    chk("d_bits64", bits64, 64'd300);
    chk("d_errs64", errs64, 64'd300);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ber_align_counter.md
BER_ALIGN_COUNTER -- requirements
Module: ber_align_counter

Interface
REQ-001 Parameter NB_BER, 64, width of the bit and error counters.
REQ-002 Parameter NB_DELAY, 9, width of the delay index; the delay search range is 0..510 (one PRBS9 period).
REQ-003 Parameter WIN_LEN, 511, number of symbols compared per candidate delay.
REQ-004 Parameter RESYNC_TH, 128, error threshold per window that triggers resync.
REQ-005 Port clock, input, 1, system clock.
REQ-006 Port reset, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-007 Port i_enable, input, 1, RX enable; low = freeze.
REQ-008 Port i_valid, input, 1, one-cycle baud strobe.
REQ-009 Port i_ref_bit, input, 1, local transmitted PRBS9 bit; qualified by i_valid.
REQ-010 Port i_rx_bit, input, 1, received decided bit; qualified by i_valid.
REQ-011 Port o_bit_count, output, NB_BER, number of compared bits since lock.
REQ-012 Port o_error_count, output, NB_BER, number of mismatches since lock.
REQ-013 Port o_locked, output, 1, high in LOCKED.
REQ-014 Port o_delay, output, NB_DELAY, selected alignment delay.

Function
REQ-015 A strobe is i_valid=1 with i_enable=1; in IDLE, i_valid is ignored.
REQ-016 History: hist[0] = i_ref_bit on the current strobe; hist[k] = i_ref_bit from k strobes earlier; shift on every strobe outside IDLE.
REQ-017 States are IDLE, FILL, SEARCH, LOCKED.
REQ-018 IDLE -> FILL on the first cycle with i_enable=1.
REQ-019 FILL -> SEARCH after 511 strobes have been received.
REQ-020 SEARCH tests candidate d = 0..510 in order, comparing i_rx_bit with hist[d] over WIN_LEN strobes per candidate and accumulating the window error count.
REQ-021 At the end of each window, if the error count is strictly less than the running minimum, the minimum and best delay are updated; ties keep the smaller delay.
REQ-022 After the d=510 window completes: o_delay = best delay, o_locked = 1, both counters = 0, and the state moves to LOCKED.
REQ-023 In LOCKED, each strobe adds 1 to o_bit_count and adds (i_rx_bit XOR hist[o_delay]) to o_error_count.
REQ-024 Counter updates are registered and visible the cycle after the strobe.
REQ-025 Each counter saturates at all-ones and does not wrap; the other counter keeps counting.
REQ-026 i_enable=0 in any state other than IDLE holds the state, history, window and counters unchanged; it does not return the block to IDLE.
REQ-027 Outputs hold their values between strobes.

Reset
REQ-028 While reset=1, asynchronously: state = IDLE; o_bit_count = 0, o_error_count = 0, o_locked = 0, o_delay = 0; history, window counter, minimum and best delay are cleared.
REQ-029 Reset asserted mid-FILL, mid-SEARCH or mid-LOCKED produces the same cleared state; operation resumes per REQ-018 after release.

Configuration
REQ-030 Macro BER_RESYNC_EN defined: in LOCKED, mismatches are also counted per WIN_LEN-strobe window; if a window reaches RESYNC_TH errors, o_locked drops the next cycle and the state goes to SEARCH from d=0 with a cleared minimum; the counters hold their last values until relock, then clear.
REQ-031 Macro BER_RESYNC_EN undefined: LOCKED is left only by reset, and no resync logic is synthesized.

Structure
REQ-032 Package ber_pkg holds the state enum, PRBS_PERIOD=511 and the default parameter constants.
REQ-033 Sub-module ref_delay_line holds the 512-bit history shift register and the indexed read port hist[d]; the controller/counters live in ber_align_counter.

Verification
REQ-034 Zero errors: WIN_LEN=511, rx = ref delayed 37 strobes -> o_locked rises after 511 + 511*511 strobes, o_delay=37, o_error_count stays 0, o_bit_count = strobes since lock.
REQ-035 Error injection: delay 5, every 100th rx bit inverted after lock, 10000 locked strobes -> o_bit_count=10000, o_error_count=100.
REQ-036 Saturation: NB_BER=8, 300 locked strobes with rx inverted -> both counters hold 255.
REQ-037 Reset at d=200 in SEARCH -> all outputs 0 and IDLE the same cycle; a later full sequence relocks at the correct delay.
REQ-038 Freeze: i_enable=0 for 1000 cycles with i_valid toggling while locked -> counters and o_delay unchanged.
REQ-039 BER_RESYNC_EN: locked at 37, stimulus delay switched to 80 -> o_locked drops within one window and relocks with o_delay=80; without the macro, o_locked stays 1 and o_error_count approximates o_bit_count/2.
